sum_arbiter: RTL and testbench

Round-robin arbiter that shares the single combinational `sum` adder between up to N sequential arithmetic units (cube root, multiplier, future units) so they can run concurrently instead of being serialised by a top-level FSM. A unit requests the adder, holds it for a burst of cycles, and stalls whenever it does not own it. The block sits between the units' `sum_in_a`/`sum_in_b`/`sum_out` ports and the one `sum` instance, and replaces the per-state input mux in the top-level controller.

---
 rtl/fun_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/sum.sv | 13 +
 rtl/sum_arbiter.sv | 156 +++++++++++++++
 tb/tb_sum_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fun_pkg.sv
// Shared constants for the arithmetic-unit cluster and the adder arbiter.
package fun_pkg;

  // Default adder width and number of units that share the adder
  localparam int SUM_W = 16;
  localparam int ARB_N = 3;

  // Arbiter ownership state
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Circular first-pending search: returns the first requester at or after
// 'start' whose request is set and which is not in the exclude mask.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  onehot,
  output logic          found
);

  logic [IW-1:0] j;

  // Walk the ring once starting at 'start' and keep the first hit
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(start) + k) % N);
      if (!found && req[j] && !excl[j]) begin
        onehot[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum.sv
// Single combinational adder shared by the arithmetic units; carry is dropped.
module sum #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  // Plain modular add, result truncated to W bits
  assign s = a + b;

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin owner of the shared 'sum' adder. A requester holds the adder
// for a burst while its req stays high; handover to the next pending
// requester happens on the release edge with no idle cycle. An optional
// hold limit forces rotation so one unit cannot starve the others.
module sum_arbiter
  import fun_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int W        = SUM_W,
  parameter int MAX_HOLD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_i,
  input  logic [N*W-1:0] b_i,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   sum_o,
  output logic           busy,
  output logic [N-1:0]   wait_o
);

  localparam int IW        = (N > 1) ? $clog2(N) : 1;
  localparam int HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  wait_q;

  logic [IW-1:0] owner_idx;
  logic [IW-1:0] owner_next;
  logic [IW-1:0] pick_start;
  logic [N-1:0]  pick_oh;
  logic          pick_found;
  logic [IW-1:0] pick_next;
  logic          owner_req;
  logic          others_req;
  logic          preempt;

  logic [W-1:0]  a_sel, b_sel;

  // Decode the current owner index from the one-hot grant
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) owner_idx = IW'(i);
    end
  end

  assign owner_next = (owner_idx == IW'(N - 1)) ? '0 : owner_idx + IW'(1);

  // Idle grants search from ptr; handover/preempt searches after the owner.
  // In IDLE gnt_q is zero, so the exclude mask is harmless there.
  assign pick_start = (state_q == IDLE) ? ptr_q : owner_next;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .excl   (gnt_q),
    .onehot (pick_oh),
    .found  (pick_found)
  );

  // Pointer value to store after granting the picked requester (wraps to 0)
  always_comb begin
    pick_next = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) pick_next = (i == N - 1) ? '0 : IW'(i + 1);
    end
  end

  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  // '>=' rather than '==' so a saturated counter still yields to a
  // requester that arrives after the owner has exceeded the limit.
  assign preempt    = (MAX_HOLD > 0) && (hold_q >= HW'(HOLD_LAST)) && others_req;

  // Next-state: grant, release/handover, forced rotation, hold counting
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_oh;
          ptr_d   = pick_next;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!owner_req || preempt) begin
          if (pick_found) begin
            gnt_d  = pick_oh;
            ptr_d  = pick_next;
            hold_d = '0;
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if ((MAX_HOLD > 0) && (hold_q < HW'(MAX_HOLD))) begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
  end

  // Control registers; async reset drops any grant immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      wait_q  <= req & ~gnt_d;
    end
  end

  // AND-OR operand mux keyed by the one-hot grant; zero operands when idle
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      a_sel = a_sel | (a_i[i*W +: W] & {W{gnt_q[i]}});
      b_sel = b_sel | (b_i[i*W +: W] & {W{gnt_q[i]}});
    end
  end

  sum #(
    .W (W)
  ) u_sum (
    .a (a_sel),
    .b (b_sel),
    .s (sum_o)
  );

  assign gnt    = gnt_q;
  assign busy   = |gnt_q;
  assign wait_o = wait_q;

endmodule

// File: tb/tb_sum_arbiter.sv
// Scoreboard bench for sum_arbiter (N=3, W=16, MAX_HOLD=4).
module tb_sum_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] a_i, b_i;
  logic [2:0]  gnt;
  logic [15:0] sum_o;
  logic        busy;
  logic [2:0]  wait_o;

  logic [15:0] opa [3];
  logic [15:0] opb [3];

  assign a_i = {opa[2], opa[1], opa[0]};
  assign b_i = {opb[2], opb[1], opb[0]};

  sum_arbiter #(.N(3), .W(16), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_i    (a_i),
    .b_i    (b_i),
    .gnt    (gnt),
    .sum_o  (sum_o),
    .busy   (busy),
    .wait_o (wait_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic [2:0] w;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] exp_sum(input logic [2:0] g);
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < 3; i++)
      if (g[i]) s = opa[i] + opb[i];
    return s;
  endfunction

  // Monitor: compare the entry scheduled for the current cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t s;
      s = q.pop_front();
      chk("stale_entry", s.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt", {29'd0, gnt}, {29'd0, e.g});
      chk("busy", {31'd0, busy}, {31'd0, |e.g});
      chk("wait_o", {29'd0, wait_o}, {29'd0, e.w});
      chk("sum_o", {16'd0, sum_o}, {16'd0, exp_sum(e.g)});
    end
  end

  // Drive req for one cycle (called at posedge+1) and queue expectation
  task automatic step(input logic [2:0] r, input logic [2:0] eg);
    exp_t e;
    req   = r;
    e.cyc = cyc + 1;
    e.g   = eg;
    e.w   = r & ~eg;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Async reset applied mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    req = 3'b000;
    #1;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait", {29'd0, wait_o}, 32'd0);
    chk("rst_sum", {16'd0, sum_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 3'b000;
    opa[0] = 16'd1000; opb[0] = 16'd234;
    opa[1] = 16'd300;  opb[1] = 16'd45;
    opa[2] = 16'd7;    opb[2] = 16'd8;
    do_reset();

    // Single request
    step(3'b001, 3'b001);
    chk("single_sum", {16'd0, sum_o}, 32'd1234);
    step(3'b001, 3'b001);
    step(3'b000, 3'b000);
    chk("single_idle_sum", {16'd0, sum_o}, 32'd0);

    // Contention: all rise together, each releases after 3 cycles
    do_reset();
    step(3'b111, 3'b001); step(3'b111, 3'b001); step(3'b111, 3'b001);
    step(3'b110, 3'b010); step(3'b110, 3'b010); step(3'b110, 3'b010);
    step(3'b100, 3'b100); step(3'b100, 3'b100); step(3'b100, 3'b100);
    step(3'b000, 3'b000);

    // Round-robin fairness and pointer wrap
    do_reset();
    step(3'b010, 3'b010);
    step(3'b011, 3'b010);
    step(3'b101, 3'b100);
    step(3'b001, 3'b001);
    step(3'b011, 3'b001);
    step(3'b010, 3'b010);
    step(3'b001, 3'b001);
    step(3'b000, 3'b000);
    step(3'b100, 3'b100);
    step(3'b000, 3'b000);
    step(3'b011, 3'b001);
    step(3'b000, 3'b000);

    // Forced rotation after 4 owned cycles
    do_reset();
    repeat (4) step(3'b011, 3'b001);
    repeat (4) step(3'b011, 3'b010);
    repeat (2) step(3'b011, 3'b001);
    step(3'b000, 3'b000);
    // Lone requester keeps the adder indefinitely
    repeat (10) step(3'b001, 3'b001);
    step(3'b000, 3'b000);

    // Overflow wraps, carry dropped
    opa[0] = 16'hFFFF; opb[0] = 16'h0002;
    step(3'b001, 3'b001);
    chk("ovf_sum", {16'd0, sum_o}, 32'h0001);
    step(3'b000, 3'b000);

    // Async reset mid-burst, then fresh arbitration starts at 0
    step(3'b010, 3'b010);
    step(3'b010, 3'b010);
    chk("pre_rst_gnt", {29'd0, gnt}, 32'd2);
    do_reset();
    step(3'b111, 3'b001);
    step(3'b110, 3'b010);
    step(3'b000, 3'b000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
